iris_feature_loader: RTL
========================

IRIS_FEATURE_LOADER -- requirements
Module: iris_feature_loader

Interface
REQ-001 Parameter N, default 8, width in bits of each feature byte and of the input stream word.
REQ-002 Parameter C, default 2, width in bits of the class code.
REQ-003 Parameter CW, default 16, width in bits of each per-class counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_data  input  N  feature word; arrives in the order SEPAL_LENGTH, SEPAL_WIDTH, PETAL_LENGTH, PETAL_WIDTH.
REQ-007 s_valid  input  1  s_data is valid.
REQ-008 s_ready  output  1  the block accepts s_data this cycle.
REQ-009 SEPAL_LENGTH, SEPAL_WIDTH, PETAL_LENGTH, PETAL_WIDTH  output  N each  registered features driving the combinational classifier.
REQ-010 cls_in  input  C  class code returned combinationally by the classifier.
REQ-011 m_cls  output  C  captured class for the current sample.
REQ-012 m_tag  output  8  sample sequence number, wrapping from 255 to 0.
REQ-013 m_valid  input/output: output  1  m_cls and m_tag are valid.
REQ-014 m_ready  input  1  downstream accepts the result.
REQ-015 cnt_clr  input  1  synchronous clear of all class counters.
REQ-016 cnt0, cnt1, cnt2  output  CW each  saturating counts of results with class 0, 1 and 2.

Function
REQ-017 The FSM SHALL have three states: COLLECT, EVAL and HOLD.
REQ-018 In COLLECT, s_ready=1; a handshake (s_valid&s_ready) writes s_data into the feature selected by a 2-bit index, then increments the index.
REQ-019 A handshake at index 3 SHALL write PETAL_WIDTH, reset the index to 0 and move to EVAL on the next cycle.
REQ-020 In EVAL (exactly one cycle), s_ready=0; the block SHALL capture cls_in into m_cls and move to HOLD, with m_valid=1 from the following cycle.
REQ-021 In HOLD, s_ready=0 and m_valid=1; m_cls and m_tag SHALL stay stable until m_valid&m_ready.
REQ-022 On m_valid&m_ready, the block SHALL return to COLLECT, drop m_valid the next cycle and increment m_tag.
REQ-023 Latency: the fourth input handshake at cycle t gives m_valid=1 at cycle t+2.
REQ-024 Feature outputs SHALL hold their last written values until overwritten; no output changes while s_valid=0.
REQ-025 The result handshake SHALL increment cnt[m_cls] by 1 when m_cls is 0..2, saturating at 2^CW-1; m_cls=3 SHALL be forwarded and counted nowhere.
REQ-026 cnt_clr SHALL zero all counters next cycle; if it coincides with an increment, the clear wins.
REQ-027 Maximum throughput is one sample every 6 cycles when m_ready is held at 1.

Reset
REQ-028 While rst_n=0: state=COLLECT, index=0, all features=0, m_cls=0, m_tag=0, m_valid=0, counters=0; s_ready=1 from the first cycle after release.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard the partial frame or the pending result; no counter is updated.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the feature-index constants and the class-code constants CLS_SETOSA=0, CLS_VERSICOLOR=1, CLS_VIRGINICA=2, CLS_INVALID=3.
REQ-031 One sub-module, iris_cls_counter, SHALL implement a single saturating counter with increment and clear; it is instantiated three times.

Verification
REQ-032 Bytes 50,30,14,2 with m_ready=1 and cls_in forced to 0 -> features 50,30,14,2; m_valid at t+2; m_cls=0, m_tag=0; cnt0=1.
REQ-033 s_valid toggling 1,0,1,0 across a frame -> only the asserted cycles are accepted, and the result arrives 2 cycles after the fourth acceptance.
REQ-034 m_ready=0 for 10 cycles in HOLD, with s_valid=1 and byte 99 on s_data -> s_ready=0, features and m_cls unchanged, no counter change.
REQ-035 CW=4, 15 class-2 results then 2 more -> cnt2 stays at 15; cnt_clr asserted in the same cycle as a class-1 handshake -> cnt1=0.
REQ-036 rst_n pulsed low after 2 bytes, then a full frame -> the result uses only the new 4 bytes, m_tag=0.
REQ-037 256 frames -> m_tag wraps from 255 to 0; cls_in=3 -> m_cls=3 and no counter increments.

Source files
------------

// File: rtl/iris_feature_loader_pkg.sv
// rtl/iris_feature_loader_pkg.sv - shared states, feature indices and class codes
package iris_feature_loader_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam logic [1:0] IDX_SEPAL_LENGTH = 2'd0;
  localparam logic [1:0] IDX_SEPAL_WIDTH  = 2'd1;
  localparam logic [1:0] IDX_PETAL_LENGTH = 2'd2;
  localparam logic [1:0] IDX_PETAL_WIDTH  = 2'd3;

  localparam logic [1:0] CLS_SETOSA     = 2'd0;
  localparam logic [1:0] CLS_VERSICOLOR = 2'd1;
  localparam logic [1:0] CLS_VIRGINICA  = 2'd2;
  localparam logic [1:0] CLS_INVALID    = 2'd3;

endpackage

// File: rtl/iris_cls_counter.sv
// rtl/iris_cls_counter.sv - saturating per-class result counter with clear
module iris_cls_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);

  localparam logic [CW-1:0] MAX_CNT = '1;

  logic [CW-1:0] r_cnt;

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/iris_feature_loader.sv
// rtl/iris_feature_loader.sv - collects four iris features, captures the class, counts results
module iris_feature_loader
  import iris_feature_loader_pkg::*;
#(
  parameter int N  = 8,
  parameter int C  = 2,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [N-1:0]  SEPAL_LENGTH,
  output logic [N-1:0]  SEPAL_WIDTH,
  output logic [N-1:0]  PETAL_LENGTH,
  output logic [N-1:0]  PETAL_WIDTH,
  input  logic [C-1:0]  cls_in,
  output logic [C-1:0]  m_cls,
  output logic [7:0]    m_tag,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic          cnt_clr,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2
);

  state_e       r_state;
  logic [1:0]   r_idx;
  logic         r_s_ready;
  logic [N-1:0] r_sepal_length;
  logic [N-1:0] r_sepal_width;
  logic [N-1:0] r_petal_length;
  logic [N-1:0] r_petal_width;
  logic [C-1:0] r_m_cls;
  logic [7:0]   r_m_tag;
  logic         r_m_valid;

  logic         w_res_hs;
  logic         w_inc0;
  logic         w_inc1;
  logic         w_inc2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= COLLECT;
      r_idx          <= IDX_SEPAL_LENGTH;
      r_s_ready      <= 1'b1;
      r_sepal_length <= '0;
      r_sepal_width  <= '0;
      r_petal_length <= '0;
      r_petal_width  <= '0;
      r_m_cls        <= '0;
      r_m_tag        <= '0;
      r_m_valid      <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (s_valid && r_s_ready) begin
            case (r_idx)
              IDX_SEPAL_LENGTH: r_sepal_length <= s_data;
              IDX_SEPAL_WIDTH:  r_sepal_width  <= s_data;
              IDX_PETAL_LENGTH: r_petal_length <= s_data;
              IDX_PETAL_WIDTH:  r_petal_width  <= s_data;
            endcase
            // The 2-bit index wraps to 0 after the last feature of a frame.
            r_idx <= r_idx + 2'd1;
            if (r_idx == IDX_PETAL_WIDTH) begin
              r_state   <= EVAL;
              r_s_ready <= 1'b0;
            end
          end
        end
        EVAL: begin
          r_m_cls   <= cls_in;
          r_m_valid <= 1'b1;
          r_state   <= HOLD;
        end
        HOLD: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_m_tag   <= r_m_tag + 8'd1;
            r_state   <= COLLECT;
          end
        end
        default: begin
          r_state   <= COLLECT;
          r_s_ready <= 1'b1;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  // Class 3 (invalid) matches no counter and is only forwarded.
  assign w_res_hs = r_m_valid && m_ready;
  assign w_inc0   = w_res_hs && (r_m_cls == C'(CLS_SETOSA));
  assign w_inc1   = w_res_hs && (r_m_cls == C'(CLS_VERSICOLOR));
  assign w_inc2   = w_res_hs && (r_m_cls == C'(CLS_VIRGINICA));

  iris_cls_counter #(.CW(CW)) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (cnt_clr),
    .i_inc (w_inc0),
    .o_cnt (cnt0)
  );

  iris_cls_counter #(.CW(CW)) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (cnt_clr),
    .i_inc (w_inc1),
    .o_cnt (cnt1)
  );

  iris_cls_counter #(.CW(CW)) u_cnt2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (cnt_clr),
    .i_inc (w_inc2),
    .o_cnt (cnt2)
  );

  assign s_ready      = r_s_ready;
  assign SEPAL_LENGTH = r_sepal_length;
  assign SEPAL_WIDTH  = r_sepal_width;
  assign PETAL_LENGTH = r_petal_length;
  assign PETAL_WIDTH  = r_petal_width;
  assign m_cls        = r_m_cls;
  assign m_tag        = r_m_tag;
  assign m_valid      = r_m_valid;

endmodule
